// File: rtl/ws_pkg.sv
// Shared types and defaults for the weight-stationary PE row and its sequencer.
package ws_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int N_PE_DEF  = 4;
    localparam int LEN_W_DEF = 8;
    localparam int ACC_W     = 2 * WIDTH_DEF;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_STREAM = 3'd2,
        S_FLUSH  = 3'd3,
        S_WAIT   = 3'd4,
        S_RESULT = 3'd5
    } state_e;

    function automatic int acc_w_of(input int width);
        return 2 * width;
    endfunction

endpackage

// File: rtl/ws_pe_sequencer_if.sv
// Host-side job/stream/result signals plus the PE-row control bus of the sequencer.
interface ws_pe_sequencer_if
    import ws_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int N_PE  = N_PE_DEF,
    parameter int LEN_W = LEN_W_DEF
);
    // valid/ready: a beat or result transfers on a rising clock edge where both
    // valid and ready are high; valid may not depend on ready, and the data is
    // held stable by the sender while valid is high and ready is low.
    logic                        start;
    logic [LEN_W-1:0]            len;
    logic [N_PE*WIDTH-1:0]       weights;
    logic                        busy;
    logic                        in_valid;
    logic                        in_ready;
    logic [WIDTH-1:0]            in_data;
    logic                        pe_ready;
    logic                        pe_rw;
    logic [N_PE*WIDTH-1:0]       pe_weight;
    logic [WIDTH-1:0]            pe_input;
    logic [N_PE*2*WIDTH-1:0]     pe_output;
    logic                        res_valid;
    logic                        res_ready;
    logic [N_PE*2*WIDTH-1:0]     res_data;

    modport slave (
        input  start, len, weights, in_valid, in_data, pe_output, res_ready,
        output busy, in_ready, pe_ready, pe_rw, pe_weight, pe_input, res_valid, res_data
    );

    modport master (
        output start, len, weights, in_valid, in_data, pe_output, res_ready,
        input  busy, in_ready, pe_ready, pe_rw, pe_weight, pe_input, res_valid, res_data
    );

endinterface

// File: rtl/ws_lane_delta.sv
// One lane: remembers the PE accumulator seen at the previous job and reports
// the wrapping difference on capture.
module ws_lane_delta
    import ws_pkg::*;
#(
    parameter int ACC = ACC_W
) (
    input  logic           w_clk,
    input  logic           w_rst_n,
    input  logic           capture_i,
    input  logic [ACC-1:0] pe_out_i,
    output logic [ACC-1:0] res_o
);

    logic [ACC-1:0] baseline_q, baseline_d;
    logic [ACC-1:0] res_q, res_d;

    always_comb begin
        baseline_d = baseline_q;
        res_d      = res_q;
        if (capture_i) begin
            res_d      = pe_out_i - baseline_q;
            baseline_d = pe_out_i;
        end
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            baseline_q <= '0;
            res_q      <= '0;
        end else begin
            baseline_q <= baseline_d;
            res_q      <= res_d;
        end
    end

    assign res_o = res_q;

endmodule

// File: rtl/ws_pe_sequencer.sv
// Runs a row of weight-stationary PEs through load / compute / output and
// returns the per-job accumulator delta of every lane.
module ws_pe_sequencer
    import ws_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int N_PE  = N_PE_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             w_clk,
    input  logic             w_rst_n,
    ws_pe_sequencer_if.slave bus,
    output state_e           dbg_state_o
);

    localparam int AW = acc_w_of(WIDTH);

    state_e                state_q, state_d;
    logic [LEN_W-1:0]      len_cnt_q, len_cnt_d;
    logic [N_PE*WIDTH-1:0] weights_q, weights_d;

    logic busy_c, in_ready_c, pe_ready_c, pe_rw_c, res_valid_c, capture_c;
    logic [N_PE*AW-1:0] res_data_w;

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (bus.start) state_d = S_LOAD;
            S_LOAD:   state_d = (len_cnt_q != '0) ? S_STREAM : S_FLUSH;
            S_STREAM: if (bus.in_valid && len_cnt_q == LEN_W'(1)) state_d = S_FLUSH;
            S_FLUSH:  state_d = S_WAIT;
            S_WAIT:   state_d = S_RESULT;
            S_RESULT: if (bus.res_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // pe_rw only drops in LOAD and FLUSH; everywhere else a low pe_ready keeps the PEs idle.
    always_comb begin
        busy_c      = (state_q != S_IDLE);
        in_ready_c  = (state_q == S_STREAM);
        pe_ready_c  = (state_q == S_LOAD) || ((state_q == S_STREAM) && bus.in_valid);
        pe_rw_c     = !((state_q == S_LOAD) || (state_q == S_FLUSH));
        res_valid_c = (state_q == S_RESULT);
        capture_c   = (state_q == S_WAIT);
    end

    always_comb begin
        len_cnt_d = len_cnt_q;
        weights_d = weights_q;
        if (state_q == S_IDLE && bus.start) begin
            len_cnt_d = bus.len;
            weights_d = bus.weights;
        end else if (state_q == S_STREAM && bus.in_valid) begin
            len_cnt_d = len_cnt_q - LEN_W'(1);
        end
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            len_cnt_q <= '0;
            weights_q <= '0;
        end else begin
            len_cnt_q <= len_cnt_d;
            weights_q <= weights_d;
        end
    end

    for (genvar i = 0; i < N_PE; i++) begin : g_lane
        ws_lane_delta #(.ACC(AW)) u_lane (
            .w_clk     (w_clk),
            .w_rst_n   (w_rst_n),
            .capture_i (capture_c),
            .pe_out_i  (bus.pe_output[i*AW +: AW]),
            .res_o     (res_data_w[i*AW +: AW])
        );
    end

    assign bus.busy      = busy_c;
    assign bus.in_ready  = in_ready_c;
    assign bus.pe_ready  = pe_ready_c;
    assign bus.pe_rw     = pe_rw_c;
    assign bus.pe_weight = weights_q;
    assign bus.pe_input  = bus.in_data;
    assign bus.res_valid = res_valid_c;
    assign bus.res_data  = res_data_w;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_ws_pe_sequencer.sv
// Bench for ws_pe_sequencer driving a behavioural row of four PEs.
module tb_ws_pe_sequencer;
    import ws_pkg::*;

    localparam int W  = 16;
    localparam int N  = 4;
    localparam int LW = 8;
    localparam int AW = 32;

    logic        w_clk   = 1'b0;
    logic        w_rst_n = 1'b0;
    state_e      dbg_state;
    int unsigned edge_cnt = 0;

    ws_pe_sequencer_if #(.WIDTH(W), .N_PE(N), .LEN_W(LW)) bus ();

    ws_pe_sequencer #(.WIDTH(W), .N_PE(N), .LEN_W(LW)) u_dut (
        .w_clk       (w_clk),
        .w_rst_n     (w_rst_n),
        .bus         (bus.slave),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 w_clk = ~w_clk;
    always @(posedge w_clk) edge_cnt <= edge_cnt + 1;

    // ---------------- PE row model (shares the reset) ----------------
    logic [W-1:0]    pe_w   [N];
    logic [AW-1:0]   pe_acc [N];
    logic [AW-1:0]   pe_out [N];
    logic [N*AW-1:0] pe_out_flat;

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            for (int i = 0; i < N; i++) begin
                pe_w[i]   <= '0;
                pe_acc[i] <= '0;
                pe_out[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (bus.pe_ready && !bus.pe_rw)      pe_w[i]   <= bus.pe_weight[i*W +: W];
                else if (bus.pe_ready && bus.pe_rw)  pe_acc[i] <= pe_acc[i] + AW'(pe_w[i]) * AW'(bus.pe_input);
                else if (!bus.pe_ready && !bus.pe_rw) pe_out[i] <= pe_acc[i];
            end
        end
    end

    always_comb begin
        pe_out_flat = '0;
        for (int i = 0; i < N; i++) pe_out_flat[i*AW +: AW] = pe_out[i];
    end
    assign bus.pe_output = pe_out_flat;

    // ---------------- scoreboard ----------------
    logic [N*AW-1:0] exp_q [$];
    logic [AW-1:0]   acc_model [N];
    int              n_checks = 0;
    int              n_pass   = 0;

    logic [N*W-1:0]  job_w;
    logic [W-1:0]    job_beats [$];
    int              job_gaps  [$];
    int unsigned     start_edge;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Per-lane dot product of the job, modulo 2^32.
    function automatic logic [N*AW-1:0] ref_delta();
        logic [N*AW-1:0] r;
        logic [AW-1:0]   s;
        r = '0;
        for (int i = 0; i < N; i++) begin
            s = '0;
            foreach (job_beats[k]) s = s + AW'(job_w[i*W +: W]) * AW'(job_beats[k]);
            r[i*AW +: AW] = s;
        end
        return r;
    endfunction

    function automatic logic [N*AW-1:0] acc_flat();
        logic [N*AW-1:0] r;
        for (int i = 0; i < N; i++) r[i*AW +: AW] = acc_model[i];
        return r;
    endfunction

    task automatic check_reset_values(input string p);
        check({p, "_busy"},      bus.busy, 1'b0);
        check({p, "_in_ready"},  bus.in_ready, 1'b0);
        check({p, "_pe_ready"},  bus.pe_ready, 1'b0);
        check({p, "_pe_rw"},     bus.pe_rw, 1'b1);
        check({p, "_pe_weight"}, bus.pe_weight, '0);
        check({p, "_res_valid"}, bus.res_valid, 1'b0);
        check({p, "_res_data"},  bus.res_data, '0);
        check({p, "_state"},     dbg_state, S_IDLE);
    endtask

    // ---------------- driver ----------------
    task automatic run_job(input int ready_delay, input bit poke_start, input int exp_lat);
        logic [N*AW-1:0] exp, held;
        int              len_j, idx, gap_left, lat;
        bit              seen;
        len_j = job_beats.size();
        exp_q.push_back(ref_delta());

        @(negedge w_clk);
        bus.start   = 1'b1;
        bus.len     = LW'(len_j);
        bus.weights = job_w;
        start_edge  = edge_cnt + 1;
        @(negedge w_clk);
        bus.start   = 1'b0;
        bus.len     = LW'($urandom);
        bus.weights = {$urandom, $urandom};
        #1;
        check("load_pe_ready",  bus.pe_ready, 1'b1);
        check("load_pe_rw",     bus.pe_rw, 1'b0);
        check("load_pe_weight", bus.pe_weight, job_w);
        check("load_busy",      bus.busy, 1'b1);

        idx      = 0;
        gap_left = (job_gaps.size() > 0) ? job_gaps[0] : 0;
        for (int t = 0; t < 2000 && idx < len_j; t++) begin
            @(negedge w_clk);
            if (bus.in_ready) begin
                if (gap_left > 0) begin
                    bus.in_valid = 1'b0;
                    gap_left--;
                    #1;
                    check("gap_pe_ready", bus.pe_ready, 1'b0);
                    check("gap_pe_rw",    bus.pe_rw, 1'b1);
                end else begin
                    bus.in_valid = 1'b1;
                    bus.in_data  = job_beats[idx];
                    #1;
                    check("beat_pe_ready", bus.pe_ready, 1'b1);
                    check("beat_pe_input", bus.pe_input, job_beats[idx]);
                    @(posedge w_clk);
                    idx++;
                    gap_left = (idx < job_gaps.size()) ? job_gaps[idx] : 0;
                end
            end
        end
        check("beats_accepted", idx, len_j);
        @(negedge w_clk);
        bus.in_valid = 1'b0;

        seen = 1'b0;
        for (int t = 0; t < 400 && !seen; t++) begin
            if (bus.res_valid) seen = 1'b1;
            else @(negedge w_clk);
        end
        lat = int'(edge_cnt - start_edge);
        check("res_valid_seen", seen, 1'b1);
        if (exp_lat >= 0) check("latency", lat, exp_lat);

        exp = exp_q.pop_front();
        check("res_data", bus.res_data, exp);
        for (int i = 0; i < N; i++) acc_model[i] = acc_model[i] + exp[i*AW +: AW];
        check("pe_output_raw", bus.pe_output, acc_flat());

        held = bus.res_data;
        for (int c = 0; c < ready_delay; c++) begin
            bus.res_ready = 1'b0;
            bus.start     = poke_start && (c == 1);
            bus.len       = LW'(3);
            @(negedge w_clk);
            bus.start = 1'b0;
            check("hold_res_valid", bus.res_valid, 1'b1);
            check("hold_res_data",  bus.res_data, held);
            check("hold_busy",      bus.busy, 1'b1);
        end
        bus.res_ready = 1'b1;
        bus.start     = poke_start;
        bus.len       = LW'(3);
        @(negedge w_clk);
        bus.res_ready = 1'b0;
        bus.start     = 1'b0;
        check("post_hs_state",     dbg_state, S_IDLE);
        check("post_hs_busy",      bus.busy, 1'b0);
        check("post_hs_res_valid", bus.res_valid, 1'b0);
    endtask

    task automatic set_scn1();
        job_w = {16'd4, 16'd3, 16'd2, 16'd1};
        job_beats = {16'd5, 16'd6, 16'd7};
        job_gaps.delete();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int len_r, gsum, g;
        bus.start = 0; bus.len = 0; bus.weights = 0;
        bus.in_valid = 0; bus.in_data = 0; bus.res_ready = 0;
        for (int i = 0; i < N; i++) acc_model[i] = '0;

        repeat (3) @(negedge w_clk);
        #1 check_reset_values("in_reset");
        w_rst_n = 1'b1;
        @(negedge w_clk);
        check_reset_values("after_reset");

        set_scn1();
        run_job(0, 1'b0, 6);
        check("scn1_res", bus.res_data, {32'd72, 32'd54, 32'd36, 32'd18});

        job_w = {4{16'd1}};
        job_beats = {16'd10, 16'd20};
        job_gaps.delete();
        run_job(0, 1'b0, 5);
        check("scn2_res", bus.res_data, {4{32'd30}});
        check("scn2_raw", bus.pe_output, {32'd102, 32'd84, 32'd66, 32'd48});

        set_scn1();
        job_gaps = {0, 2, 0};
        run_job(0, 1'b0, 8);

        job_w = {$urandom, $urandom};
        job_beats.delete();
        job_gaps.delete();
        run_job(0, 1'b0, 3);
        check("len0_res", bus.res_data, '0);

        set_scn1();
        run_job(5, 1'b1, 6);

        job_w = {4{16'hFFFF}};
        job_beats = {16'hFFFF, 16'hFFFF};
        job_gaps.delete();
        run_job(0, 1'b0, 5);
        check("wrap_res", bus.res_data, {4{32'hFFFC0002}});

        // Abort a job mid-stream with reset.
        @(negedge w_clk);
        bus.start = 1'b1; bus.len = LW'(5); bus.weights = {$urandom, $urandom};
        @(negedge w_clk);
        bus.start = 1'b0; bus.in_valid = 1'b1; bus.in_data = 16'd3;
        repeat (2) @(negedge w_clk);
        check("abort_in_stream", dbg_state, S_STREAM);
        w_rst_n = 1'b0;
        #1 check_reset_values("mid_reset");
        bus.in_valid = 1'b0;
        @(negedge w_clk);
        w_rst_n = 1'b1;
        for (int i = 0; i < N; i++) acc_model[i] = '0;
        exp_q.delete();

        set_scn1();
        run_job(0, 1'b0, 6);
        check("rerun_res", bus.res_data, {32'd72, 32'd54, 32'd36, 32'd18});

        for (int j = 0; j < 10; j++) begin
            len_r = $urandom_range(0, 12);
            job_w = {$urandom, $urandom};
            job_beats.delete();
            job_gaps.delete();
            gsum = 0;
            for (int k = 0; k < len_r; k++) begin
                job_beats.push_back(W'($urandom));
                g = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 2) : 0;
                job_gaps.push_back(g);
                gsum += g;
            end
            run_job($urandom_range(0, 3), 1'($urandom_range(0, 1)), len_r + 3 + gsum);
        end

        job_w = {$urandom, $urandom};
        job_beats.delete();
        job_gaps.delete();
        for (int k = 0; k < 255; k++) job_beats.push_back(W'($urandom));
        run_job(1, 1'b0, 258);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
